// File: rtl/measure_pkg.sv
// Shared definitions for the measureClifford readout chain: value width,
// accumulator FSM states and signed saturation limits.
package measure_pkg;

    localparam int NUM_QUBITS_DEFAULT = 5;

    // Per-shot value width: the qubit count plus sign and headroom bits.
    function automatic int val_w(input int num_qubits);
        return num_qubits + 2;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } acc_state_t;

    // Most positive value representable in a w-bit two's-complement number.
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Most negative value representable in a w-bit two's-complement number.
    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/sat_add_signed.sv
// Combinational W-bit signed adder that clamps to the representable range
// and flags when clamping happened.
module sat_add_signed
    import measure_pkg::*;
#(
    parameter int W = 20
)(
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    output logic signed [W-1:0] o_sum,
    output logic                o_ovf
);

    localparam logic signed [W-1:0] SAT_MAX = W'(sat_max(W));
    localparam logic signed [W-1:0] SAT_MIN = W'(sat_min(W));

    logic [W:0] w_full;

    // Add one bit wider; the top two bits disagree exactly on signed overflow.
    always_comb begin
        w_full = {i_a[W-1], i_a} + {i_b[W-1], i_b};
        o_ovf  = w_full[W] ^ w_full[W-1];
        o_sum  = w_full[W-1:0];
        if (o_ovf) begin
            // The wide sign bit tells which way the true result went.
            o_sum = w_full[W] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/shot_accumulator.sv
// Batch accumulator for per-shot measurement values: sum, count, min and max
// over a programmable number of shots, one batch per start pulse.
module shot_accumulator
    import measure_pkg::*;
#(
    parameter int NUM_QUBITS = NUM_QUBITS_DEFAULT,
    parameter int SHOT_W     = 10,
    parameter int ACC_W      = 20,
    localparam int VAL_W     = val_w(NUM_QUBITS)
)(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [SHOT_W-1:0]       i_num_shots,
    input  logic signed [VAL_W-1:0] i_value,
    input  logic                    i_valid,
    output logic                    o_busy,
    output logic                    o_done,
    output logic signed [ACC_W-1:0] o_sum,
    output logic [SHOT_W-1:0]       o_count,
    output logic signed [VAL_W-1:0] o_min,
    output logic signed [VAL_W-1:0] o_max,
    output logic                    o_overflow
);

    acc_state_t              r_state;
    acc_state_t              w_state_nxt;
    logic [SHOT_W-1:0]       r_target;
    logic [SHOT_W-1:0]       r_count;
    logic [SHOT_W-1:0]       w_count_inc;
    logic signed [ACC_W-1:0] r_sum;
    logic signed [ACC_W-1:0] w_val_ext;
    logic signed [ACC_W-1:0] w_sum_sat;
    logic                    w_add_ovf;
    logic signed [VAL_W-1:0] r_min;
    logic signed [VAL_W-1:0] r_max;
    logic                    r_ovf;
    logic                    r_first;

    assign w_count_inc = r_count + SHOT_W'(1);
    assign w_val_ext   = ACC_W'(i_value);

    sat_add_signed #(
        .W(ACC_W)
    ) u_sat_add (
        .i_a  (r_sum),
        .i_b  (w_val_ext),
        .o_sum(w_sum_sat),
        .o_ovf(w_add_ovf)
    );

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a batch ends on the sample that brings count to target.
    // NOTE: the default is assigned first so no path leaves w_state_nxt unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_num_shots == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (i_valid && (w_count_inc == r_target)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Batch datapath: clear on start, accumulate valid samples in ACCUM, hold otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_target <= '0;
            r_count  <= '0;
            r_sum    <= '0;
            r_min    <= '0;
            r_max    <= '0;
            r_ovf    <= 1'b0;
            r_first  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_target <= i_num_shots;
                        r_count  <= '0;
                        r_sum    <= '0;
                        r_min    <= '0;
                        r_max    <= '0;
                        r_ovf    <= 1'b0;
                        r_first  <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (i_valid) begin
                        r_sum   <= w_sum_sat;
                        r_ovf   <= r_ovf | w_add_ovf;
                        r_count <= w_count_inc;
                        r_first <= 1'b0;
                        if (r_first || (i_value < r_min)) begin
                            r_min <= i_value;
                        end
                        if (r_first || (i_value > r_max)) begin
                            r_max <= i_value;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy     = (r_state == ST_ACCUM);
    assign o_done     = (r_state == ST_DONE);
    assign o_sum      = r_sum;
    assign o_count    = r_count;
    assign o_min      = r_min;
    assign o_max      = r_max;
    assign o_overflow = r_ovf;

endmodule

// File: tb/tb_shot_accumulator.sv
// Directed bench for shot_accumulator. Two instances share the stimulus: one at
// the default accumulator width and one at ACC_W=8 to reach saturation.
module tb_shot_accumulator;

    localparam int SHOT_W = 10;
    localparam int VAL_W  = 7;
    localparam int ACC_D  = 20;
    localparam int ACC_8  = 8;

    typedef struct {
        longint sum_d;
        bit     ovf_d;
        longint sum_8;
        bit     ovf_8;
        longint count;
        longint vmin;
        longint vmax;
    } result_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [SHOT_W-1:0]       num_shots;
    logic signed [VAL_W-1:0] value;
    logic                    valid;

    logic                    busy_d, done_d, ovf_d;
    logic signed [ACC_D-1:0] sum_d;
    logic [SHOT_W-1:0]       count_d;
    logic signed [VAL_W-1:0] min_d, max_d;

    logic                    busy_8, done_8, ovf_8;
    logic signed [ACC_8-1:0] sum_8;
    logic [SHOT_W-1:0]       count_8;
    logic signed [VAL_W-1:0] min_8, max_8;

    int total = 0;
    int bad   = 0;

    result_t sb[$];
    result_t exp_r;

    longint m_sum_d, m_sum_8, m_cnt, m_min, m_max, m_target;
    bit     m_ovf_d, m_ovf_8, m_first;

    always #5 clk = ~clk;

    shot_accumulator #(.NUM_QUBITS(5), .SHOT_W(SHOT_W), .ACC_W(ACC_D)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_shots(num_shots),
        .i_value(value), .i_valid(valid), .o_busy(busy_d), .o_done(done_d),
        .o_sum(sum_d), .o_count(count_d), .o_min(min_d), .o_max(max_d),
        .o_overflow(ovf_d)
    );

    shot_accumulator #(.NUM_QUBITS(5), .SHOT_W(SHOT_W), .ACC_W(ACC_8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_shots(num_shots),
        .i_value(value), .i_valid(valid), .o_busy(busy_8), .o_done(done_8),
        .o_sum(sum_8), .o_count(count_8), .o_min(min_8), .o_max(max_8),
        .o_overflow(ovf_8)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference saturating add at width w.
    function automatic longint sat_add(input longint a, input longint b,
                                       input int w, output bit o);
        longint lim = longint'(1) <<< (w - 1);
        longint s   = a + b;
        o = 1'b0;
        if (s > lim - 1) begin
            s = lim - 1;
            o = 1'b1;
        end else if (s < -lim) begin
            s = -lim;
            o = 1'b1;
        end
        return s;
    endfunction

    function automatic result_t model_result();
        result_t r;
        r.sum_d = m_sum_d;
        r.ovf_d = m_ovf_d;
        r.sum_8 = m_sum_8;
        r.ovf_8 = m_ovf_8;
        r.count = m_cnt;
        r.vmin  = m_min;
        r.vmax  = m_max;
        return r;
    endfunction

    task automatic check_results(input string tag, input result_t e);
        check({tag, ".sum"},    sum_d,   e.sum_d);
        check({tag, ".ovf"},    ovf_d,   e.ovf_d);
        check({tag, ".sum8"},   sum_8,   e.sum_8);
        check({tag, ".ovf8"},   ovf_8,   e.ovf_8);
        check({tag, ".count"},  count_d, e.count);
        check({tag, ".count8"}, count_8, e.count);
        check({tag, ".min"},    min_d,   e.vmin);
        check({tag, ".max"},    max_d,   e.vmax);
        check({tag, ".min8"},   min_8,   e.vmin);
        check({tag, ".max8"},   max_8,   e.vmax);
    endtask

    task automatic check_all_zero(input string tag);
        result_t z;
        z = '{0, 0, 0, 0, 0, 0, 0};
        check({tag, ".busy"},  busy_d, 0);
        check({tag, ".done"},  done_d, 0);
        check({tag, ".busy8"}, busy_8, 0);
        check({tag, ".done8"}, done_8, 0);
        check_results(tag, z);
    endtask

    // Accept a start at the next edge; optionally drive a sample on that same cycle.
    task automatic start_batch(input string tag, input int n, input bit v_too, input int v);
        start     = 1'b1;
        num_shots = n[SHOT_W-1:0];
        valid     = v_too;
        value     = v[VAL_W-1:0];
        m_target  = n;
        m_sum_d   = 0;
        m_sum_8   = 0;
        m_ovf_d   = 0;
        m_ovf_8   = 0;
        m_cnt     = 0;
        m_min     = 0;
        m_max     = 0;
        m_first   = 1;
        if (n == 0) sb.push_back(model_result());
        @(negedge clk);
        start = 1'b0;
        valid = 1'b0;
        check({tag, ".busy"},  busy_d, (n != 0));
        check({tag, ".busy8"}, busy_8, (n != 0));
        check({tag, ".count0"}, count_d, 0);
        check({tag, ".ovf0_8"}, ovf_8, 0);
    endtask

    task automatic sample(input int v);
        bit o;
        valid = 1'b1;
        value = v[VAL_W-1:0];
        m_sum_d = sat_add(m_sum_d, v, ACC_D, o);
        m_ovf_d = m_ovf_d | o;
        m_sum_8 = sat_add(m_sum_8, v, ACC_8, o);
        m_ovf_8 = m_ovf_8 | o;
        m_cnt++;
        if (m_first || v < m_min) m_min = v;
        if (m_first || v > m_max) m_max = v;
        m_first = 0;
        if (m_cnt == m_target) sb.push_back(model_result());
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic gap(input int k, input bit pulse_start);
        for (int i = 0; i < k; i++) begin
            start     = pulse_start && (i == 0);
            num_shots = 10'd7;
            @(negedge clk);
            start = 1'b0;
            check("gap.busy", busy_d, 1);
        end
    endtask

    // Called in the cycle the batch should report done; checks the one-cycle
    // pulse and that results hold afterwards. junk drives valid/start during DONE.
    task automatic expect_done(input string tag, input bit junk);
        check({tag, ".done"},  done_d, 1);
        check({tag, ".done8"}, done_8, 1);
        check({tag, ".busy_in_done"}, busy_d, 0);
        check({tag, ".sb_size"}, sb.size(), 1);
        if (sb.size() > 0) begin
            exp_r = sb.pop_front();
            check_results(tag, exp_r);
            if (junk) begin
                valid     = 1'b1;
                value     = -7'sd30;
                start     = 1'b1;
                num_shots = 10'd2;
            end
            @(negedge clk);
            valid = 1'b0;
            start = 1'b0;
            check({tag, ".done_drop"},  done_d, 0);
            check({tag, ".done_drop8"}, done_8, 0);
            check({tag, ".idle_busy"},  busy_d, 0);
            check_results({tag, ".hold"}, exp_r);
        end
    endtask

    initial begin
        int v;
        rst       = 1'b1;
        start     = 1'b0;
        num_shots = '0;
        value     = '0;
        valid     = 1'b0;

        // Reset held three cycles with valid toggling.
        for (int i = 0; i < 3; i++) begin
            valid = ~valid;
            value = 7'sd9;
            @(negedge clk);
            check("rst.done", done_d, 0);
            check("rst.busy", busy_d, 0);
        end
        check_all_zero("rst");
        rst   = 1'b0;
        valid = 1'b0;
        @(negedge clk);

        // Basic batch.
        start_batch("basic", 4, 0, 0);
        sample(3);
        sample(-5);
        sample(10);
        sample(0);
        expect_done("basic", 0);

        // Zero shots: done in the cycle after the start edge.
        start_batch("zero", 0, 0, 0);
        expect_done("zero", 0);

        // Gaps, sample on the start cycle, mid-batch start, junk during DONE.
        start_batch("gaps", 3, 1, 50);
        sample(1);
        gap(2, 1);
        sample(2);
        gap(2, 0);
        sample(3);
        expect_done("gaps", 1);

        // Saturation on the narrow instance; the wide one stays exact.
        start_batch("sat", 3, 0, 0);
        sample(63);
        sample(63);
        sample(63);
        expect_done("sat", 0);
        start_batch("sat_clr", 1, 0, 0);
        check("sat_clr.ovf8", ovf_8, 0);
        check("sat_clr.sum8", sum_8, 0);
        sample(-1);
        expect_done("sat_clr", 0);

        // Negative saturation on the narrow instance.
        start_batch("nsat", 3, 0, 0);
        sample(-64);
        sample(-64);
        sample(-64);
        expect_done("nsat", 0);

        // Reset in the middle of a batch.
        start_batch("rstmid", 5, 0, 0);
        sample(7);
        sample(7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("rstmid");
        check("rstmid.sb_empty", sb.size(), 0);
        start_batch("after_rst", 1, 0, 0);
        sample(-2);
        expect_done("after_rst", 0);

        // Longer batch with pseudo-random values.
        start_batch("rand", 20, 0, 0);
        for (int i = 0; i < 20; i++) begin
            v = int'($urandom_range(0, 127)) - 64;
            sample(v);
        end
        expect_done("rand", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shot_accumulator.md
Name: shot_accumulator

Overview:
- Downstream stage of measureClifford. Consumes one per-shot measurement value per handshake.
- Accumulates a programmable number of shots and reports sum, count, min and max to the host/readout logic.
- Runs one batch per i_start. Pulses o_done when the batch completes.

Parameters:
- NUM_QUBITS, 5, qubit count of the upstream stage. The value width is VAL_W = NUM_QUBITS+2.
- SHOT_W, 10, width of the shot-count request and the counter. Max batch is 2^SHOT_W-1.
- ACC_W, 20, width of the signed accumulator. The default cannot overflow (VAL_W+SHOT_W <= ACC_W).

Ports:
- i_clk, input, 1, single clock. All state updates on the rising edge.
- i_rst, input, 1, synchronous, active-high reset.
- i_start, input, 1, begin a batch. Sampled in IDLE only.
- i_num_shots, input, SHOT_W, shots in the batch. Latched on the cycle i_start is accepted.
- i_value, input, NUM_QUBITS+2, signed two's-complement shot value. Driven by upstream o_value.
- i_valid, input, 1, upstream o_ready. Every cycle it is high in ACCUM is one sample.
- o_busy, output, 1, high in ACCUM.
- o_done, output, 1, one-cycle pulse in the DONE state.
- o_sum, output, ACC_W, signed running/final sum.
- o_count, output, SHOT_W, samples accepted this batch.
- o_min, output, NUM_QUBITS+2, signed minimum sample.
- o_max, output, NUM_QUBITS+2, signed maximum sample.
- o_overflow, output, 1, sticky saturation flag for the batch.

Behaviour:
- Reset, whenever i_rst=1 at an edge, regardless of state:
  - state=IDLE.
  - All outputs 0.
  - Latched target 0.
- FSM states are IDLE, ACCUM, DONE.
- IDLE:
  - i_valid is ignored.
  - i_start=1 latches i_num_shots, clears sum/count/min/max/overflow, and sets a first-sample flag.
  - Next state is ACCUM, or DONE if i_num_shots=0.
- ACCUM:
  - On each edge with i_valid=1: sum += sign-extended i_value, count += 1.
  - The first sample loads both min and max. Later samples update them with signed compares.
  - When the post-increment count equals the target, next state is DONE.
  - i_start is ignored. Gaps in i_valid are allowed, with no timeout.
- DONE:
  - Lasts exactly one cycle with o_done=1.
  - Next state is IDLE. i_valid and i_start are ignored in this cycle.
- Results hold their final values in IDLE until the next accepted i_start clears them.
- Sample on the same cycle as an accepted i_start: ignored. Accumulation starts the following cycle.
- Latency: o_done is high in the cycle immediately after the edge that captured the final sample. o_sum/o_count/o_min/o_max are already final in that cycle.
- Zero shots: o_done is high in the cycle after the start edge. All results are 0.
- Arithmetic:
  - The sum is computed at ACC_W+1 bits.
  - On signed overflow, o_sum saturates to +2^(ACC_W-1)-1 or -2^(ACC_W-1), and o_overflow=1 (sticky until next start).
  - Saturated sums keep saturating. Count still increments.
- o_busy = (state==ACCUM). o_busy is 0 in DONE.

Decomposition:
- Shared package (measure_pkg):
  - NUM_QUBITS default.
  - VAL_W derivation.
  - FSM state enum (IDLE/ACCUM/DONE).
  - Signed saturation limits as functions of width.
- One natural sub-module: sat_add_signed. It is a combinational ACC_W adder with saturation and an overflow bit.
- The FSM, counter and min/max stay in shot_accumulator.

Test Plan:
- Reset: hold i_rst=1 for 3 cycles with i_valid toggling -> all outputs 0, o_busy=0, o_done never pulses.
- Basic batch: i_num_shots=4, then valid samples 3,-5,10,0 back-to-back -> o_sum=8, o_count=4, o_min=-5, o_max=10, o_overflow=0. o_done is high exactly one cycle, the cycle after the 4th sample.
- Zero shots: i_start with i_num_shots=0 -> o_done the next cycle, o_sum=0, o_count=0, o_min=o_max=0.
- Gaps and ignored inputs: i_num_shots=3; i_valid high on the start cycle (value 50), then samples 1,2,3 with 2-cycle gaps; i_start pulsed mid-batch; i_valid high during DONE -> o_sum=6, o_count=3, o_min=1, o_max=3. The mid-batch start has no effect.
- Saturation (ACC_W=8): i_num_shots=3, samples 63,63,63 -> o_sum=127, o_overflow=1, o_count=3. The next i_start clears o_overflow to 0.
- Reset mid-batch: i_num_shots=5, 2 samples (7,7), then i_rst for 1 cycle -> IDLE with all outputs 0. A new batch of 1 sample (-2) gives o_sum=-2, o_count=1.
